// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Selection is either a fixed channel index or round-robin over requesting channels.
module stream_mux_rr #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_ch,
    output logic                   out_valid,
    input  logic                   out_ready
);

    logic [SEL_W-1:0]  rr_ptr;
    logic [DATA_W-1:0] data_p0;
    logic [SEL_W-1:0]  ch_p0;
    logic              vld_p0;

    logic              load_en;
    logic [N_CH-1:0]   grant;
    logic [SEL_W-1:0]  grant_idx;
    logic              grant_any;
    logic [DATA_W-1:0] grant_data;

    // Channel index offs places after base, modulo N_CH (offs is 1..N_CH).
    function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= N_CH) begin
            sum = sum - N_CH;
        end
        return SEL_W'(sum);
    endfunction

    assign load_en = ~vld_p0 | out_ready;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        if (mode) begin
            if ((int'(sel) < N_CH) && in_valid[sel]) begin
                grant[sel] = 1'b1;
                grant_idx  = sel;
                grant_any  = 1'b1;
            end
        end else begin
            // Search starts just after the last served channel.
            for (int k = 1; k <= N_CH; k++) begin
                if (!grant_any && in_valid[wrap_idx(rr_ptr, k)]) begin
                    grant[wrap_idx(rr_ptr, k)] = 1'b1;
                    grant_idx = wrap_idx(rr_ptr, k);
                    grant_any = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                grant_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Ready is held low while in reset even though the empty output stage would allow a load.
    assign in_ready = grant & {N_CH{load_en & rst_n}};

    // Stage p0: output register, loaded only when empty or being drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            ch_p0   <= '0;
            rr_ptr  <= SEL_W'(N_CH - 1);
        end else if (load_en) begin
            if (grant_any) begin
                data_p0 <= grant_data;
                ch_p0   <= grant_idx;
                vld_p0  <= 1'b1;
                rr_ptr  <= grant_idx;
            end else begin
                vld_p0  <= 1'b0;
            end
        end
    end

    assign out_data  = data_p0;
    assign out_ch    = ch_p0;
    assign out_valid = vld_p0;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: a cycle model predicts grants and
// queues expected output beats, which are popped when the DUT delivers them.
module tb_stream_mux_rr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic       out_ready = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [31:0] in_data = 32'h0;
    logic [3:0] in_valid = 4'h0;
    logic [3:0] in_ready;
    logic [7:0] out_data;
    logic [1:0] out_ch;
    logic       out_valid;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] c;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      exp_b;
    logic       ok;
    logic [1:0] m_ptr = 2'd3;
    logic       m_vld = 1'b0;
    logic [3:0] e;
    logic [3:0] prev_rdy;

    stream_mux_rr #(.N_CH(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model_grant();
        logic [3:0] g;
        int c;
        g = 4'b0;
        if (!rst_n || (m_vld && !out_ready)) return g;
        if (mode) begin
            g[sel] = in_valid[sel];
        end else begin
            for (int k = 1; k <= 4; k++) begin
                c = (int'(m_ptr) + k) % 4;
                if (in_valid[c]) begin
                    g[c] = 1'b1;
                    break;
                end
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        m_ptr = 2'd3;
        m_vld = 1'b0;
        exp_q.delete();
    endtask

    // Advance the model across one rising edge, queueing any predicted transfer.
    task automatic tick();
        logic [3:0] g;
        logic       le;
        g  = model_grant();
        le = !m_vld || out_ready;
        @(posedge clk);
        if (le) begin
            m_vld = |g;
            for (int i = 0; i < 4; i++) begin
                if (g[i]) begin
                    exp_q.push_back({in_data[i*8 +: 8], 2'(i)});
                    m_ptr = 2'(i);
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b0; out_ready = 1'b1; in_valid = 4'hF;
        in_data = {8'h40, 8'h30, 8'h20, 8'h10};
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 4'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
            errors++;
            $display("FAIL reset_hold: in_ready=%b out_valid=%b out_data=%h out_ch=%0d required 0000 0 00 0",
                     in_ready, out_valid, out_data, out_ch);
        end
        in_valid = 4'h0; rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 4'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: in_ready=%b out_valid=%b out_data=%h out_ch=%0d required 0000 0 00 0",
                         i, in_ready, out_valid, out_data, out_ch);
            end
            tick();
        end
    endtask

    task automatic test_fixed_select();
        mode = 1'b1; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) sel = 2'd3;
            @(negedge clk);
            e = (i < 4) ? 4'b0100 : 4'b1000;
            checks++;
            if (in_ready !== e || in_ready !== model_grant() || out_valid !== m_vld) begin
                errors++;
                $display("FAIL fixed_grant cycle %0d: in_ready=%b out_valid=%b required %b %b",
                         i, in_ready, out_valid, e, m_vld);
            end
            if (out_valid && out_ready) begin
                ok = exp_q.size() != 0;
                if (ok) exp_b = exp_q.pop_front();
                checks++;
                if (!ok || {out_data, out_ch} !== exp_b) begin
                    errors++;
                    $display("FAIL fixed_sb cycle %0d: got %h/%0d required %h/%0d (queued=%0d)",
                             i, out_data, out_ch, exp_b.d, exp_b.c, ok);
                end
            end
            if (i >= 1) begin
                checks++;
                if (out_data !== ((i < 5) ? 8'h30 : 8'h40) || out_ch !== ((i < 5) ? 2'd2 : 2'd3)) begin
                    errors++;
                    $display("FAIL fixed_out cycle %0d: out_data=%h out_ch=%0d required %h %0d",
                             i, out_data, out_ch, (i < 5) ? 8'h30 : 8'h40, (i < 5) ? 2 : 3);
                end
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        mode = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            e = 4'b0001 << (i % 4);
            checks++;
            if (in_ready !== e || in_ready !== model_grant() || out_valid !== m_vld) begin
                errors++;
                $display("FAIL rr_grant cycle %0d: in_ready=%b out_valid=%b required %b %b",
                         i, in_ready, out_valid, e, m_vld);
            end
            if (out_valid && out_ready) begin
                ok = exp_q.size() != 0;
                if (ok) exp_b = exp_q.pop_front();
                checks++;
                if (!ok || {out_data, out_ch} !== exp_b) begin
                    errors++;
                    $display("FAIL rr_sb cycle %0d: got %h/%0d required %h/%0d (queued=%0d)",
                             i, out_data, out_ch, exp_b.d, exp_b.c, ok);
                end
            end
            if (i >= 1) begin
                checks++;
                if (out_ch !== 2'((i - 1) % 4)) begin
                    errors++;
                    $display("FAIL rr_order cycle %0d: out_ch=%0d required %0d", i, out_ch, (i - 1) % 4);
                end
            end
            tick();
        end
    endtask

    task automatic test_sparse();
        mode = 1'b0; in_valid = 4'b1010; out_ready = 1'b1;
        prev_rdy = 4'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== model_grant() || out_valid !== m_vld || in_ready === prev_rdy ||
                (in_ready !== 4'b0010 && in_ready !== 4'b1000)) begin
                errors++;
                $display("FAIL sparse_grant cycle %0d: in_ready=%b out_valid=%b required %b %b (prev %b)",
                         i, in_ready, out_valid, model_grant(), m_vld, prev_rdy);
            end
            prev_rdy = in_ready;
            if (out_valid && out_ready) begin
                ok = exp_q.size() != 0;
                if (ok) exp_b = exp_q.pop_front();
                checks++;
                if (!ok || {out_data, out_ch} !== exp_b) begin
                    errors++;
                    $display("FAIL sparse_sb cycle %0d: got %h/%0d required %h/%0d (queued=%0d)",
                             i, out_data, out_ch, exp_b.d, exp_b.c, ok);
                end
            end
            tick();
        end
        in_valid = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 4'b0 || out_valid !== (i == 0)) begin
                errors++;
                $display("FAIL sparse_drain cycle %0d: in_ready=%b out_valid=%b required 0000 %0d",
                         i, in_ready, out_valid, i == 0);
            end
            if (out_valid && out_ready) begin
                ok = exp_q.size() != 0;
                if (ok) exp_b = exp_q.pop_front();
                checks++;
                if (!ok || {out_data, out_ch} !== exp_b) begin
                    errors++;
                    $display("FAIL sparse_drain_sb: got %h/%0d required %h/%0d (queued=%0d)",
                             out_data, out_ch, exp_b.d, exp_b.c, ok);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        mode = 1'b1; sel = 2'd1; in_valid = 4'hF; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0010 || in_ready !== model_grant()) begin
            errors++;
            $display("FAIL bp_load: in_ready=%b required 0010", in_ready);
        end
        tick();
        mode = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h20 || out_ch !== 2'd1 || in_ready !== 4'b0 ||
                in_ready !== model_grant()) begin
                errors++;
                $display("FAIL bp_stall cycle %0d: out_valid=%b out_data=%h out_ch=%0d in_ready=%b required 1 20 1 0000",
                         i, out_valid, out_data, out_ch, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            e = (i == 0) ? 4'b0100 : 4'b1000;
            checks++;
            if (in_ready !== e || in_ready !== model_grant() || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_resume cycle %0d: in_ready=%b out_valid=%b required %b 1", i, in_ready, out_valid, e);
            end
            ok = exp_q.size() != 0;
            if (ok) exp_b = exp_q.pop_front();
            checks++;
            if (!ok || {out_data, out_ch} !== exp_b ||
                out_data !== ((i == 0) ? 8'h20 : 8'h30)) begin
                errors++;
                $display("FAIL bp_sb cycle %0d: got %h/%0d required %h/%0d (queued=%0d)",
                         i, out_data, out_ch, exp_b.d, exp_b.c, ok);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        mode = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
        repeat (2) tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: out_valid=%b required 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0 || in_ready !== 4'b0) begin
            errors++;
            $display("FAIL midrst_async: out_valid=%b out_data=%h out_ch=%0d in_ready=%b required 0 00 0 0000",
                     out_valid, out_data, out_ch, in_ready);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0001 || in_ready !== model_grant() || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_first: in_ready=%b out_valid=%b required 0001 0", in_ready, out_valid);
        end
        tick();
        @(negedge clk);
        ok = exp_q.size() != 0;
        if (ok) exp_b = exp_q.pop_front();
        checks++;
        if (!ok || out_valid !== 1'b1 || {out_data, out_ch} !== exp_b || out_ch !== 2'd0 || out_data !== 8'h10) begin
            errors++;
            $display("FAIL midrst_beat: out_valid=%b got %h/%0d required 10/0 (queued=%0d)",
                     out_valid, out_data, out_ch, ok);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_fixed_select();
        test_round_robin();
        test_sparse();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
